// File: rtl/packetizer.sv
// rtl/packetizer.sv - packs 16-bit payload words two at a time into 48-bit flits
// Optional flit/packet counters are built when PACKETIZER_STATS_EN is defined.
module packetizer #(
   parameter logic [15:0] TAIL_CTRL = 16'hFFFF,
   parameter logic [15:0] BODY_CTRL = 16'h0000,
   parameter logic [15:0] PAD_WORD  = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        data_valid,
   input  logic        data_last,
   output logic        data_ready,
   output logic [47:0] flit_out,
   output logic        flit_valid,
   input  logic        flit_ready
`ifdef PACKETIZER_STATS_EN
   ,
   output logic [15:0] flit_count,
   output logic [15:0] pkt_count
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HALF  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_hold;
   logic [15:0] w_next_hold;
   logic [47:0] r_flit;
   logic [47:0] w_next_flit;
   logic        w_in_xfer;
   logic        w_out_xfer;

   // A full flit frees the slot in the same cycle it is taken, so ready looks at flit_ready.
   assign data_ready = (r_state != ST_FULL) || flit_ready;
   assign flit_valid = (r_state == ST_FULL);
   assign flit_out   = r_flit;
   assign w_in_xfer  = data_valid && data_ready;
   assign w_out_xfer = flit_valid && flit_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_EMPTY;
         r_hold  <= 16'h0000;
         r_flit  <= 48'h0;
      end else begin
         r_state <= w_next_state;
         r_hold  <= w_next_hold;
         r_flit  <= w_next_flit;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_hold  = r_hold;
      w_next_flit  = r_flit;
      case (r_state)
         ST_EMPTY, ST_FULL: begin
            if ((r_state == ST_FULL) && w_out_xfer) begin
               w_next_state = ST_EMPTY;
            end
            // In FULL an input transfer implies the flit is leaving, so treat it as EMPTY.
            if (w_in_xfer) begin
               if (data_last) begin
                  w_next_flit  = {data_in, PAD_WORD, TAIL_CTRL};
                  w_next_state = ST_FULL;
               end else begin
                  w_next_hold  = data_in;
                  w_next_state = ST_HALF;
               end
            end
         end
         ST_HALF: begin
            if (w_in_xfer) begin
               w_next_flit  = {r_hold, data_in, data_last ? TAIL_CTRL : BODY_CTRL};
               w_next_state = ST_FULL;
            end
         end
         default: begin
            w_next_state = ST_EMPTY;
         end
      endcase
   end

`ifdef PACKETIZER_STATS_EN
   logic [15:0] r_flit_count;
   logic [15:0] r_pkt_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flit_count <= 16'h0000;
         r_pkt_count  <= 16'h0000;
      end else if (w_out_xfer) begin
         r_flit_count <= r_flit_count + 16'd1;
         if (r_flit[15:0] == TAIL_CTRL) begin
            r_pkt_count <= r_pkt_count + 16'd1;
         end
      end
   end

   assign flit_count = r_flit_count;
   assign pkt_count  = r_pkt_count;
`endif

endmodule

// File: tb/tb_packetizer.sv
// tb/tb_packetizer.sv - self-checking bench for packetizer
// Covers the PACKETIZER_STATS_EN counters when that macro is defined.
module tb_packetizer;

   localparam logic [15:0] TAIL = 16'hFFFF;
   localparam logic [15:0] BODY = 16'h0000;
   localparam logic [15:0] PAD  = 16'h0000;

   logic        clk;
   logic        reset;
   logic [15:0] data_in;
   logic        data_valid;
   logic        data_last;
   logic        data_ready;
   logic [47:0] flit_out;
   logic        flit_valid;
   logic        flit_ready;
`ifdef PACKETIZER_STATS_EN
   logic [15:0] flit_count;
   logic [15:0] pkt_count;
`endif

   packetizer dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .data_ready (data_ready),
      .flit_out   (flit_out),
      .flit_valid (flit_valid),
      .flit_ready (flit_ready)
`ifdef PACKETIZER_STATS_EN
      ,
      .flit_count (flit_count),
      .pkt_count  (pkt_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        l;
      logic        fr;
      logic        e_rdy;
      logic        e_fv;
      logic        chk_flit;
      logic [47:0] e_flit;
   } vec_t;

   vec_t        tbl[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] cur_pkt[$];
   logic [47:0] exp_q[$];
   logic [47:0] obs_q[$];
   logic        chk_rules  = 1'b0;
   logic        prev_stall = 1'b0;
   logic [47:0] prev_flit  = 48'h0;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [15:0] d, input logic l, input logic fr,
                      input logic e_rdy, input logic e_fv, input logic chk_flit,
                      input logic [47:0] e_flit);
      vec_t t;
      t.v = v; t.d = d; t.l = l; t.fr = fr;
      t.e_rdy = e_rdy; t.e_fv = e_fv; t.chk_flit = chk_flit; t.e_flit = e_flit;
      tbl.push_back(t);
   endtask

   // Reference model: a finished packet of N words becomes ceil(N/2) flits, tail on the last.
   task automatic model_accept(input logic [15:0] w, input logic last);
      int n;
      logic [15:0] second;
      logic [15:0] ctrl;
      cur_pkt.push_back(w);
      if (last) begin
         n = cur_pkt.size();
         for (int i = 0; i < n; i += 2) begin
            second = (i + 1 < n) ? cur_pkt[i+1] : PAD;
            ctrl   = (i + 2 >= n) ? TAIL : BODY;
            exp_q.push_back({cur_pkt[i], second, ctrl});
         end
         cur_pkt.delete();
      end
   endtask

   // Drive at the falling edge, then observe the pre-edge handshake 1 ns later.
   task automatic drive(input logic v, input logic [15:0] d, input logic l, input logic fr);
      @(negedge clk);
      data_valid = v;
      data_in    = d;
      data_last  = l;
      flit_ready = fr;
      #1;
      if (reset) begin
         cur_pkt.delete();
         prev_stall = 1'b0;
      end else begin
         if (chk_rules) begin
            check("ready_rule", 48'(data_ready), 48'(!flit_valid || flit_ready));
            if (prev_stall) begin
               check("stall_valid", 48'(flit_valid), 48'h1);
               check("stall_flit", flit_out, prev_flit);
            end
         end
         if (data_valid && data_ready) model_accept(data_in, data_last);
         if (flit_valid && flit_ready) obs_q.push_back(flit_out);
         prev_stall = flit_valid && !flit_ready;
         prev_flit  = flit_out;
      end
   endtask

   task automatic tick;
      @(posedge clk);
   endtask

   initial begin
      logic got;
      int   n;
      reset      = 1'b1;
      data_valid = 1'b0;
      data_in    = 16'h0;
      data_last  = 1'b0;
      flit_ready = 1'b1;
      tick();

      // cycle-by-cycle directed table; expectations describe the state before each edge
      add(1, 16'h1234, 0, 1, 1, 0, 1, 48'h0);
      add(1, 16'hABCD, 1, 1, 1, 0, 1, 48'h0);
      add(0, 16'h0000, 0, 1, 1, 1, 1, 48'h1234_ABCD_FFFF);
      add(0, 16'h0000, 0, 1, 1, 0, 0, 48'h0);
      add(1, 16'h3232, 0, 1, 1, 0, 0, 48'h0);
      add(1, 16'h6767, 0, 1, 1, 0, 0, 48'h0);
      add(1, 16'h6547, 0, 1, 1, 1, 1, 48'h3232_6767_0000);
      add(1, 16'h4576, 1, 1, 1, 0, 0, 48'h0);
      add(1, 16'h6969, 1, 1, 1, 1, 1, 48'h6547_4576_FFFF);
      add(0, 16'h0000, 0, 1, 1, 1, 1, 48'h6969_0000_FFFF);
      add(1, 16'h1234, 0, 0, 1, 0, 0, 48'h0);
      add(1, 16'hABCD, 1, 0, 1, 0, 0, 48'h0);
      for (int i = 0; i < 5; i++) add(1, 16'h5555, 0, 0, 0, 1, 1, 48'h1234_ABCD_FFFF);
      add(1, 16'h5555, 0, 1, 1, 1, 1, 48'h1234_ABCD_FFFF);
      add(0, 16'h0000, 1, 1, 1, 0, 0, 48'h0);
      add(1, 16'h7777, 1, 1, 1, 0, 0, 48'h0);
      add(0, 16'h0000, 1, 1, 1, 1, 1, 48'h5555_7777_FFFF);
      add(0, 16'h0000, 1, 1, 1, 0, 0, 48'h0);
      add(0, 16'h0000, 0, 1, 1, 0, 0, 48'h0);

      reset = 1'b0;
      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].fr);
         check($sformatf("tbl%0d_ready", i), 48'(data_ready), 48'(tbl[i].e_rdy));
         check($sformatf("tbl%0d_valid", i), 48'(flit_valid), 48'(tbl[i].e_fv));
         if (tbl[i].chk_flit) check($sformatf("tbl%0d_flit", i), flit_out, tbl[i].e_flit);
         tick();
      end

`ifdef PACKETIZER_STATS_EN
      drive(0, 16'h0, 0, 1);
      check("stats_flits", 48'(flit_count), 48'd6);
      check("stats_pkts", 48'(pkt_count), 48'd5);
      tick();
`endif

      // reset mid-packet drops the held word
      drive(1, 16'h4566, 0, 1);
      tick();
      reset = 1'b1;
      drive(0, 16'h0, 0, 1);
      tick();
      reset = 1'b0;
      obs_q.delete();
      exp_q.delete();
      drive(0, 16'h0, 0, 1);
      check("rst_valid", 48'(flit_valid), 48'h0);
      check("rst_ready", 48'(data_ready), 48'h1);
      check("rst_flit", flit_out, 48'h0);
      tick();
      drive(1, 16'hAAAA, 0, 1);
      tick();
      drive(1, 16'hBBBB, 1, 1);
      check("rst_seq_valid_pre", 48'(flit_valid), 48'h0);
      tick();
      drive(0, 16'h0, 0, 1);
      check("rst_seq_valid", 48'(flit_valid), 48'h1);
      check("rst_seq_flit", flit_out, 48'hAAAA_BBBB_FFFF);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 16'h0, 0, 1);
         tick();
      end
      check("rst_seq_count", 48'(obs_q.size()), 48'd1);
      if (obs_q.size() > 0) check("rst_seq_obs", obs_q[0], 48'hAAAA_BBBB_FFFF);

      // randomized traffic against the packet-level model
      obs_q.delete();
      exp_q.delete();
      cur_pkt.delete();
      chk_rules = 1'b1;
      for (int c = 0; c < 800; c++) begin
         drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 2) == 0,
               $urandom_range(0, 9) < 6);
         tick();
      end
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         drive(1, 16'($urandom), 1, 1);
         got = data_ready;
         tick();
      end
      check("rand_close_pkt", 48'(got), 48'h1);
      for (int c = 0; c < 5; c++) begin
         drive(0, 16'h0, 0, 1);
         tick();
      end
      chk_rules = 1'b0;
      check("rand_flit_count", 48'(obs_q.size()), 48'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("rand_flit%0d", i), obs_q[i], exp_q[i]);

`ifdef PACKETIZER_STATS_EN
      // wrap: single-word packets give one flit per cycle
      reset = 1'b1;
      drive(0, 16'h0, 0, 1);
      tick();
      reset = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 70000 && !got; c++) begin
         drive(1, 16'h1111, 1, 1);
         got = (flit_count == 16'hFFFF);
         if (!got) tick();
      end
      check("wrap_reached", 48'(got), 48'h1);
      check("wrap_pkts_ffff", 48'(pkt_count), 48'hFFFF);
      tick();
      drive(0, 16'h0, 0, 1);
      check("wrap_flits_zero", 48'(flit_count), 48'h0);
      check("wrap_pkts_zero", 48'(pkt_count), 48'h0);
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
